// File: rtl/id_stage_v3.sv
// id_stage_v3: registered MIPS integer decode stage (IF/ID -> ID/EX) with valid/ready handshake.
// Define ID_FORWARDING_EN to forward EX/MEM results into the operands; otherwise RAW hazards stall.
module id_stage_v3 #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [31:0]       i_inst,
  output logic              o_rreg1_en,
  output logic [4:0]        o_rreg1_addr,
  output logic              o_rreg2_en,
  output logic [4:0]        o_rreg2_addr,
  input  logic [DATA_W-1:0] i_reg1_data,
  input  logic [DATA_W-1:0] i_reg2_data,
  input  logic              i_ex_wreg,
  input  logic [4:0]        i_ex_wreg_addr,
  input  logic [DATA_W-1:0] i_ex_wdata,
  input  logic              i_mem_wreg,
  input  logic [4:0]        i_mem_wreg_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [PC_W-1:0]   o_pc,
  output logic [2:0]        o_alusel,
  output logic [7:0]        o_aluop,
  output logic [DATA_W-1:0] o_reg1_data,
  output logic [DATA_W-1:0] o_reg2_data,
  output logic              o_wreg,
  output logic [4:0]        o_wreg_addr,
  output logic              o_instvalid
);
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b011;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SLL  = 8'h7C;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [2:0]        alusel;
    logic [7:0]        aluop;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic              wreg;
    logic [4:0]        waddr;
    logic              instvalid;
  } idex_t;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  assign op    = i_inst[31:26];
  assign rs    = i_inst[25:21];
  assign rt    = i_inst[20:16];
  assign rd    = i_inst[15:11];
  assign shamt = i_inst[10:6];
  assign funct = i_inst[5:0];
  assign imm16 = i_inst[15:0];

  logic              legal, rd1_en, rd2_en, wr_en;
  logic [2:0]        sel;
  logic [7:0]        aop;
  logic [4:0]        waddr;
  logic [DATA_W-1:0] imm;

  always_comb begin
    legal  = 1'b0;
    rd1_en = 1'b0;
    rd2_en = 1'b0;
    wr_en  = 1'b0;
    sel    = 3'b000;
    aop    = 8'h00;
    waddr  = 5'd0;
    imm    = '0;
    case (op)
      6'h00: begin
        case (funct)
          6'h24, 6'h25, 6'h26, 6'h27: begin
            legal = 1'b1; sel = SEL_LOGIC; aop = {2'b00, funct};
            rd1_en = 1'b1; rd2_en = 1'b1; wr_en = 1'b1; waddr = rd;
          end
          6'h21, 6'h23: begin
            legal = 1'b1; sel = SEL_ARITH; aop = {2'b00, funct};
            rd1_en = 1'b1; rd2_en = 1'b1; wr_en = 1'b1; waddr = rd;
          end
          6'h00, 6'h02, 6'h03: begin
            // operand 1 carries shamt; the all-zero word is a NOP and never writes
            legal = 1'b1; sel = SEL_SHIFT;
            aop = (funct == 6'h00) ? OP_SLL : {2'b00, funct};
            rd2_en = 1'b1; wr_en = (i_inst != 32'h0); waddr = rd;
            imm = DATA_W'(shamt);
          end
          default: ;
        endcase
      end
      6'h0C, 6'h0D, 6'h0E: begin
        legal = 1'b1; sel = SEL_LOGIC;
        aop = (op == 6'h0C) ? OP_AND : (op == 6'h0D) ? OP_OR : OP_XOR;
        rd1_en = 1'b1; wr_en = 1'b1; waddr = rt; imm = DATA_W'(imm16);
      end
      6'h09: begin
        legal = 1'b1; sel = SEL_ARITH; aop = OP_ADDU;
        rd1_en = 1'b1; wr_en = 1'b1; waddr = rt; imm = DATA_W'($signed(imm16));
      end
      6'h0F: begin
        legal = 1'b1; sel = SEL_LOGIC; aop = OP_OR;
        rd1_en = 1'b1; wr_en = 1'b1; waddr = rt; imm = DATA_W'({imm16, 16'h0000});
      end
      default: ;
    endcase
  end

  logic [DATA_W-1:0] src1, src2;
  logic              hazard;
`ifdef ID_FORWARDING_EN
  always_comb begin
    src1 = i_reg1_data;
    if (rs == 5'd0)                               src1 = '0;
    else if (i_ex_wreg && i_ex_wreg_addr == rs)   src1 = i_ex_wdata;
    else if (i_mem_wreg && i_mem_wreg_addr == rs) src1 = i_mem_wdata;
    src2 = i_reg2_data;
    if (rt == 5'd0)                               src2 = '0;
    else if (i_ex_wreg && i_ex_wreg_addr == rt)   src2 = i_ex_wdata;
    else if (i_mem_wreg && i_mem_wreg_addr == rt) src2 = i_mem_wdata;
  end
  assign hazard = 1'b0;
`else
  assign src1 = (rs == 5'd0) ? '0 : i_reg1_data;
  assign src2 = (rt == 5'd0) ? '0 : i_reg2_data;
  assign hazard =
    (rd1_en && rs != 5'd0 && ((i_ex_wreg && i_ex_wreg_addr == rs) || (i_mem_wreg && i_mem_wreg_addr == rs))) ||
    (rd2_en && rt != 5'd0 && ((i_ex_wreg && i_ex_wreg_addr == rt) || (i_mem_wreg && i_mem_wreg_addr == rt)));
  logic unused_wdata;
  assign unused_wdata = ^{i_ex_wdata, i_mem_wdata};
`endif

  idex_t dec, idex_d, idex_q;
  logic  valid_d, valid_q, load;

  always_comb begin
    dec.pc        = i_pc;
    dec.alusel    = sel;
    dec.aluop     = aop;
    dec.reg1      = rd1_en ? src1 : imm;
    dec.reg2      = rd2_en ? src2 : imm;
    dec.wreg      = wr_en;
    dec.waddr     = waddr;
    dec.instvalid = legal;
  end

  assign o_ready = (!valid_q || i_ready) && !hazard && !rst && !i_flush;
  assign load    = i_valid && o_ready;

  // An empty register is all zeros, whether emptied by flush or by draining.
  always_comb begin
    valid_d = valid_q;
    idex_d  = idex_q;
    if (i_flush) begin
      valid_d = 1'b0;
      idex_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      idex_d  = dec;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
      idex_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idex_q  <= idex_d;
    end
  end

  assign o_rreg1_en   = rd1_en;
  assign o_rreg1_addr = rs;
  assign o_rreg2_en   = rd2_en;
  assign o_rreg2_addr = rt;
  assign o_valid      = valid_q;
  assign o_pc         = idex_q.pc;
  assign o_alusel     = idex_q.alusel;
  assign o_aluop      = idex_q.aluop;
  assign o_reg1_data  = idex_q.reg1;
  assign o_reg2_data  = idex_q.reg2;
  assign o_wreg       = idex_q.wreg;
  assign o_wreg_addr  = idex_q.waddr;
  assign o_instvalid  = idex_q.instvalid;
endmodule

// File: tb/tb_id_stage_v3.sv
// tb_id_stage_v3: directed literal cases followed by randomized traffic against a behavioural decode model.
module tb_id_stage_v3;
  logic        clk = 1'b0;
  logic        rst, i_flush, i_valid, i_ready;
  logic [31:0] i_pc, i_inst, i_reg1_data, i_reg2_data, i_ex_wdata, i_mem_wdata;
  logic        i_ex_wreg, i_mem_wreg;
  logic [4:0]  i_ex_wreg_addr, i_mem_wreg_addr;
  logic        o_ready, o_rreg1_en, o_rreg2_en, o_valid, o_wreg, o_instvalid;
  logic [4:0]  o_rreg1_addr, o_rreg2_addr, o_wreg_addr;
  logic [31:0] o_pc, o_reg1_data, o_reg2_data;
  logic [2:0]  o_alusel;
  logic [7:0]  o_aluop;

  always #5 clk = ~clk;

  id_stage_v3 #(.DATA_W(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_inst(i_inst),
    .o_rreg1_en(o_rreg1_en), .o_rreg1_addr(o_rreg1_addr),
    .o_rreg2_en(o_rreg2_en), .o_rreg2_addr(o_rreg2_addr),
    .i_reg1_data(i_reg1_data), .i_reg2_data(i_reg2_data),
    .i_ex_wreg(i_ex_wreg), .i_ex_wreg_addr(i_ex_wreg_addr), .i_ex_wdata(i_ex_wdata),
    .i_mem_wreg(i_mem_wreg), .i_mem_wreg_addr(i_mem_wreg_addr), .i_mem_wdata(i_mem_wdata),
    .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_alusel(o_alusel), .o_aluop(o_aluop),
    .o_reg1_data(o_reg1_data), .o_reg2_data(o_reg2_data),
    .o_wreg(o_wreg), .o_wreg_addr(o_wreg_addr), .o_instvalid(o_instvalid)
  );

  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit        legal;
    bit [2:0]  sel;
    bit [7:0]  op;
    bit        r1en, r2en, wr;
    bit [4:0]  wa;
    bit [31:0] imm;
  } dec_t;

  function automatic dec_t mdec(input logic [31:0] x);
    dec_t d;
    logic [5:0] opc, fn;
    d = '0;
    opc = x[31:26];
    fn  = x[5:0];
    if (opc == 6'h00 && fn inside {6'h24, 6'h25, 6'h26, 6'h27, 6'h21, 6'h23}) begin
      d.legal = 1; d.sel = (fn >= 6'h24) ? 3'd1 : 3'd3; d.op = {2'b00, fn};
      d.r1en = 1; d.r2en = 1; d.wr = 1; d.wa = x[15:11];
    end else if (opc == 6'h00 && fn inside {6'h00, 6'h02, 6'h03}) begin
      d.legal = 1; d.sel = 3'd2; d.op = (fn == 6'h00) ? 8'h7C : {2'b00, fn};
      d.r2en = 1; d.wr = (x != 32'h0); d.wa = x[15:11]; d.imm = {27'b0, x[10:6]};
    end else if (opc inside {6'h0C, 6'h0D, 6'h0E}) begin
      d.legal = 1; d.sel = 3'd1; d.op = 8'h24 + {6'b0, opc[1:0]};
      d.r1en = 1; d.wr = 1; d.wa = x[20:16]; d.imm = {16'b0, x[15:0]};
    end else if (opc == 6'h09) begin
      d.legal = 1; d.sel = 3'd3; d.op = 8'h21;
      d.r1en = 1; d.wr = 1; d.wa = x[20:16]; d.imm = {{16{x[15]}}, x[15:0]};
    end else if (opc == 6'h0F) begin
      d.legal = 1; d.sel = 3'd1; d.op = 8'h25;
      d.r1en = 1; d.wr = 1; d.wa = x[20:16]; d.imm = {x[15:0], 16'h0};
    end
    return d;
  endfunction

  function automatic bit [31:0] msrc(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'h0;
`ifdef ID_FORWARDING_EN
    if (i_ex_wreg && i_ex_wreg_addr == a) return i_ex_wdata;
    if (i_mem_wreg && i_mem_wreg_addr == a) return i_mem_wdata;
`endif
    return rf;
  endfunction

  function automatic bit hit(input bit en, input logic [4:0] a);
    return en && a != 5'd0 && ((i_ex_wreg && i_ex_wreg_addr == a) || (i_mem_wreg && i_mem_wreg_addr == a));
  endfunction

  function automatic bit mhaz();
`ifdef ID_FORWARDING_EN
    return 1'b0;
`else
    dec_t d;
    d = mdec(i_inst);
    return hit(d.r1en, i_inst[25:21]) || hit(d.r2en, i_inst[20:16]);
`endif
  endfunction

  bit        m_valid, m_iv, m_ivchk, m_legal, m_wr;
  bit [31:0] m_pc, m_r1, m_r2;
  bit [2:0]  m_sel;
  bit [7:0]  m_op;
  bit [4:0]  m_wa;

  function automatic bit mready();
    return (!m_valid || i_ready) && !mhaz() && !rst && !i_flush;
  endfunction

  always @(posedge clk) begin
    dec_t d;
    d = mdec(i_inst);
    if (rst || i_flush) begin
      m_valid <= 0; m_iv <= 0; m_ivchk <= 1;
    end else if (i_valid && mready()) begin
      m_valid <= 1; m_pc <= i_pc; m_sel <= d.sel; m_op <= d.op; m_wr <= d.wr; m_wa <= d.wa;
      m_r1 <= d.r1en ? msrc(i_inst[25:21], i_reg1_data) : d.imm;
      m_r2 <= d.r2en ? msrc(i_inst[20:16], i_reg2_data) : d.imm;
      m_iv <= d.legal; m_legal <= d.legal; m_ivchk <= 1;
    end else if (m_valid && i_ready) begin
      m_valid <= 0; m_ivchk <= 0;
    end
  end

  always @(negedge clk) begin
    dec_t d;
    d = mdec(i_inst);
    chk("ready", 32'(o_ready), 32'(mready()));
    chk("rreg1_addr", 32'(o_rreg1_addr), 32'(i_inst[25:21]));
    chk("rreg2_addr", 32'(o_rreg2_addr), 32'(i_inst[20:16]));
    if (i_valid) begin
      chk("rreg1_en", 32'(o_rreg1_en), 32'(d.r1en));
      chk("rreg2_en", 32'(o_rreg2_en), 32'(d.r2en));
    end
    chk("valid", 32'(o_valid), 32'(m_valid));
    if (m_valid || m_ivchk) chk("instvalid", 32'(o_instvalid), 32'(m_iv));
    if (m_valid) begin
      chk("pc", o_pc, m_pc);
      chk("alusel", 32'(o_alusel), 32'(m_sel));
      chk("aluop", 32'(o_aluop), 32'(m_op));
      chk("wreg", 32'(o_wreg), 32'(m_wr));
      if (m_legal) begin
        chk("reg1", o_reg1_data, m_r1);
        chk("reg2", o_reg2_data, m_r2);
        chk("waddr", 32'(o_wreg_addr), 32'(m_wa));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
    i_valid = v; i_inst = inst; i_pc = pc; i_reg1_data = r1; i_reg2_data = r2;
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [5:0]  rfn[6] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h21, 6'h23};
    logic [5:0]  sfn[3] = '{6'h00, 6'h02, 6'h03};
    logic [5:0]  iop[5] = '{6'h0C, 6'h0D, 6'h0E, 6'h09, 6'h0F};
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    rs  = 5'($urandom_range(0, 3));
    rt  = 5'($urandom_range(0, 3));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 7))
      0, 1:    return {6'h00, rs, rt, rd, 5'h00, rfn[3'($urandom_range(0, 5))]};
      2:       return {6'h00, 5'h00, rt, rd, imm[10:6], sfn[2'($urandom_range(0, 2))]};
      3, 4:    return {iop[3'($urandom_range(0, 4))], rs, rt, imm};
      5:       return {6'h3F, rs, rt, imm};
      6:       return ($urandom_range(0, 1) != 0) ? 32'h0 : {6'h00, rs, rt, rd, 5'h00, 6'h3E};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1; i_flush = 0; i_ready = 1;
    set_in(0, 32'h0, 32'h0, 32'h0, 32'h0);
    i_ex_wreg = 0; i_ex_wreg_addr = 0; i_ex_wdata = 0;
    i_mem_wreg = 0; i_mem_wreg_addr = 0; i_mem_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_instvalid", 32'(o_instvalid), 32'h0);
    chk("rst_outs", {o_pc | o_reg1_data | o_reg2_data}, 32'h0);
    chk("rst_ctl", {16'h0, o_aluop, o_wreg_addr, o_alusel}, 32'h0);
    chk("rst_wreg", 32'(o_wreg), 32'h0);
    rst = 0;

    // ORI $3,$1,0x00F0
    set_in(1, 32'h342300F0, 32'h100, 32'h12340000, 32'hDEADBEEF);
    #1 chk("ori_ready", 32'(o_ready), 32'h1);
    tick();
    chk("ori_valid", 32'(o_valid), 32'h1);
    chk("ori_alusel", 32'(o_alusel), 32'h1);
    chk("ori_aluop", 32'(o_aluop), 32'h25);
    chk("ori_reg1", o_reg1_data, 32'h12340000);
    chk("ori_reg2", o_reg2_data, 32'h000000F0);
    chk("ori_wreg", 32'(o_wreg), 32'h1);
    chk("ori_waddr", 32'(o_wreg_addr), 32'h3);

    // ADDIU $2,$0,0xFFFF then LUI $4,0x8000
    set_in(1, 32'h2402FFFF, 32'h104, 32'h55, 32'h66);
    tick();
    chk("addiu_reg1", o_reg1_data, 32'h0);
    chk("addiu_reg2", o_reg2_data, 32'hFFFFFFFF);
    chk("addiu_aluop", 32'(o_aluop), 32'h21);
    set_in(1, 32'h3C048000, 32'h108, 32'h77, 32'h88);
    tick();
    chk("lui_reg2", o_reg2_data, 32'h80000000);
    chk("lui_waddr", 32'(o_wreg_addr), 32'h4);

    // ADDU $5,$1,$2 with EX and MEM both writing $1
    set_in(1, 32'h00222821, 32'h10C, 32'h11, 32'h22);
    i_ex_wreg = 1; i_ex_wreg_addr = 5'd1; i_ex_wdata = 32'hAA;
    i_mem_wreg = 1; i_mem_wreg_addr = 5'd1; i_mem_wdata = 32'hBB;
`ifdef ID_FORWARDING_EN
    #1 chk("fwd_ready", 32'(o_ready), 32'h1);
    tick();
    chk("fwd_reg1", o_reg1_data, 32'hAA);
    chk("fwd_reg2", o_reg2_data, 32'h22);
    i_ex_wreg = 0; i_mem_wreg = 0;
`else
    #1 chk("haz_ready_exmem", 32'(o_ready), 32'h0);
    tick();
    chk("haz_bubble", 32'(o_valid), 32'h0);
    i_ex_wreg = 0;
    #1 chk("haz_ready_mem", 32'(o_ready), 32'h0);
    tick();
    i_mem_wreg = 0;
    #1 chk("haz_ready_clear", 32'(o_ready), 32'h1);
    tick();
    chk("haz_reg1", o_reg1_data, 32'h11);
    chk("haz_pc", o_pc, 32'h10C);
`endif

    // stall for three cycles with a new instruction waiting
    set_in(1, 32'h34410001, 32'h200, 32'h1, 32'h2);
    tick();
    i_ready = 0;
    set_in(1, 32'h38A51234, 32'h204, 32'h3, 32'h4);
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_ready", 32'(o_ready), 32'h0);
      chk("stall_pc", o_pc, 32'h200);
      tick();
    end
    chk("stall_hold", o_pc, 32'h200);
    i_ready = 1;
    #1 chk("unstall_ready", 32'(o_ready), 32'h1);
    tick();
    chk("unstall_pc", o_pc, 32'h204);
    chk("unstall_aluop", 32'(o_aluop), 32'h26);

    // illegal opcode
    set_in(1, 32'hFC000000, 32'h300, 32'h5, 32'h6);
    tick();
    chk("ill_valid", 32'(o_valid), 32'h1);
    chk("ill_instvalid", 32'(o_instvalid), 32'h0);
    chk("ill_wreg", 32'(o_wreg), 32'h0);
    chk("ill_ctl", {24'h0, o_aluop} | 32'(o_alusel), 32'h0);

    // flush wins over a load
    set_in(1, 32'h342300F0, 32'h400, 32'h7, 32'h8);
    i_flush = 1;
    #1 chk("flush_ready", 32'(o_ready), 32'h0);
    tick();
    i_flush = 0; i_valid = 0;
    chk("flush_valid", 32'(o_valid), 32'h0);
    chk("flush_instvalid", 32'(o_instvalid), 32'h0);
    tick();
    chk("flush_nocapture", 32'(o_valid), 32'h0);

    for (int c = 0; c < 3000; c++) begin
      rst             = ($urandom_range(0, 199) == 0);
      i_flush         = ($urandom_range(0, 24) == 0);
      i_valid         = ($urandom_range(0, 3) != 0);
      i_ready         = ($urandom_range(0, 3) != 0);
      i_inst          = rnd_inst();
      i_pc            = $urandom;
      i_reg1_data     = $urandom;
      i_reg2_data     = $urandom;
      i_ex_wreg       = ($urandom_range(0, 2) == 0);
      i_ex_wreg_addr  = 5'($urandom_range(0, 3));
      i_ex_wdata      = $urandom;
      i_mem_wreg      = ($urandom_range(0, 2) == 0);
      i_mem_wreg_addr = 5'($urandom_range(0, 3));
      i_mem_wdata     = $urandom;
      tick();
    end
    rst = 0; i_flush = 0; i_valid = 0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
